seq_pattern_tx: RTL and testbench

Serial bit-pattern transmitter that drives the single-bit `w` input of the team's serial sequence-detector FSMs.
- Latches a parallel pattern of up to MAX_LEN bits and shifts it out MSB-first, one bit per clock.
- Supports optional repetition with idle gaps between repetitions.
- Signals completion with a one-cycle pulse.
- Acts as the stimulus/producer end of the detector's `w`/`z` interface, in-system and in benches.

---
 rtl/seq_pattern_tx.sv | 200 ++++++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter. It latches a parallel pattern and shifts it
// out MSB-first, one bit per clock, on w. Optional repetitions can be
// separated by idle gap cycles. Completion is flagged by a one-cycle done
// pulse, and a rejected start request is flagged by a one-cycle err pulse.
module seq_pattern_tx #(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1),
  parameter int GAP_CYCLES = 2,
  parameter int REP_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  input  logic               abort,
  output logic               w,
  output logic               w_valid,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [LEN_W-1:0]   bit_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t state_reg, state_next;

  // pat_reg holds the accepted pattern left-aligned, so the first bit to send
  // is always at MAX_LEN-1 no matter what len is. sh_reg holds the bits that
  // remain to be sent in the current pass, also left-aligned.
  logic [MAX_LEN-1:0] pat_reg, pat_next;
  logic [MAX_LEN-1:0] sh_reg, sh_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [REP_W-1:0]   rep_reg, rep_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;

  logic               w_reg, w_next;
  logic               w_valid_reg, w_valid_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic [LEN_W-1:0]   bit_idx_reg, bit_idx_next;

  logic               len_ok;
  logic               last_bit;
  logic [MAX_LEN-1:0] aligned;

  assign len_ok   = (len != '0) && (len <= MAX_LEN_L);
  assign last_bit = (bit_idx_reg == '0);
  assign aligned  = pattern << (MAX_LEN_L - len);

  // State and registered outputs; rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pat_reg     <= '0;
      sh_reg      <= '0;
      len_reg     <= '0;
      rep_reg     <= '0;
      gap_reg     <= '0;
      w_reg       <= 1'b0;
      w_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      bit_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pat_reg     <= pat_next;
      sh_reg      <= sh_next;
      len_reg     <= len_next;
      rep_reg     <= rep_next;
      gap_reg     <= gap_next;
      w_reg       <= w_next;
      w_valid_reg <= w_valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      bit_idx_reg <= bit_idx_next;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && len_ok) state_next = SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (last_bit) begin
          if (rep_reg != '0) state_next = (GAP_CYCLES > 0) ? GAP : SHIFT;
          else               state_next = DONE;
        end
      end
      GAP: begin
        if (abort)               state_next = IDLE;
        else if (gap_reg == '0)  state_next = SHIFT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the datapath and of the outputs. Outputs default to the
  // idle pattern, so every path that does not drive a bit leaves w at 0.
  always_comb begin
    pat_next     = pat_reg;
    sh_next      = sh_reg;
    len_next     = len_reg;
    rep_next     = rep_reg;
    gap_next     = gap_reg;
    w_next       = 1'b0;
    w_valid_next = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;
    bit_idx_next = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_next     = aligned;
            sh_next      = aligned << 1;
            len_next     = len;
            rep_next     = reps;
            w_next       = aligned[MAX_LEN-1];
            w_valid_next = 1'b1;
            busy_next    = 1'b1;
            bit_idx_next = len - LEN_ONE;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!abort) begin
          if (!last_bit) begin
            w_next       = sh_reg[MAX_LEN-1];
            sh_next      = sh_reg << 1;
            w_valid_next = 1'b1;
            busy_next    = 1'b1;
            bit_idx_next = bit_idx_reg - LEN_ONE;
          end else if (rep_reg != '0) begin
            rep_next  = rep_reg - REP_ONE;
            busy_next = 1'b1;
            if (GAP_CYCLES > 0) begin
              gap_next = GAP_LOAD;
            end else begin
              // No gap: restart the pattern on the very next cycle.
              w_next       = pat_reg[MAX_LEN-1];
              sh_next      = pat_reg << 1;
              w_valid_next = 1'b1;
              bit_idx_next = len_reg - LEN_ONE;
            end
          end else begin
            done_next = 1'b1;
          end
        end
      end
      GAP: begin
        if (!abort) begin
          busy_next = 1'b1;
          if (gap_reg == '0) begin
            w_next       = pat_reg[MAX_LEN-1];
            sh_next      = pat_reg << 1;
            w_valid_next = 1'b1;
            bit_idx_next = len_reg - LEN_ONE;
          end else begin
            gap_next = gap_reg - GAP_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  assign w       = w_reg;
  assign w_valid = w_valid_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign bit_idx = bit_idx_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx. Two instances are driven with the same inputs:
// one with a 2-cycle gap and one with back-to-back repetitions. The reference
// model expands each accepted request into the full list of expected output
// cycles and then replays that list one cycle at a time.
module tb_seq_pattern_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  reps;
  logic        abort;

  logic       w_o       [2];
  logic       w_valid_o [2];
  logic       busy_o    [2];
  logic       done_o    [2];
  logic       err_o     [2];
  logic [4:0] bit_idx_o [2];

  int n_checks = 0;
  int n_err    = 0;
  int cycle    = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.MAX_LEN(16), .GAP_CYCLES(2), .REP_W(4)) dut_gap (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .abort(abort), .w(w_o[0]), .w_valid(w_valid_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .bit_idx(bit_idx_o[0])
  );

  seq_pattern_tx #(.MAX_LEN(16), .GAP_CYCLES(0), .REP_W(4)) dut_b2b (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .abort(abort), .w(w_o[1]), .w_valid(w_valid_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .bit_idx(bit_idx_o[1])
  );

  typedef struct packed {
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] bit_idx;
  } exp_t;

  exp_t mq [2][$];
  exp_t cur [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Expand one accepted request into its complete list of output cycles.
  task automatic expand(input int m, input int gap);
    exp_t e;
    for (int r = 0; r <= int'(reps); r++) begin
      for (int i = int'(len) - 1; i >= 0; i--) begin
        e = '0;
        e.w = pattern[i];
        e.w_valid = 1'b1;
        e.busy = 1'b1;
        e.bit_idx = 5'(i);
        mq[m].push_back(e);
      end
      if (r < int'(reps)) begin
        for (int g = 0; g < gap; g++) begin
          e = '0;
          e.busy = 1'b1;
          mq[m].push_back(e);
        end
      end
    end
    e = '0;
    e.done = 1'b1;
    mq[m].push_back(e);
  endtask

  // Advance both models by one clock using the inputs present at the edge.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mq[m].delete();
        cur[m] = '0;
      end else if (cur[m].busy && abort) begin
        mq[m].delete();
        cur[m] = '0;
      end else if (mq[m].size() > 0) begin
        cur[m] = mq[m].pop_front();
      end else if (cur[m].done) begin
        cur[m] = '0;
      end else if (start) begin
        if (len >= 5'd1 && len <= 5'd16) begin
          $display("tx inst=%0d cycle=%0d len=%0d reps=%0d pattern=%04h", m, cycle, len, reps, pattern);
          expand(m, (m == 0) ? 2 : 0);
          cur[m] = mq[m].pop_front();
        end else begin
          cur[m] = '0;
          cur[m].err = 1'b1;
        end
      end else begin
        cur[m] = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    model_step();
    #1;
    for (int m = 0; m < 2; m++) begin
      string p;
      p = (m == 0) ? "gap2" : "gap0";
      check({p, ".w"},       32'(w_o[m]),       32'(cur[m].w));
      check({p, ".w_valid"}, 32'(w_valid_o[m]), 32'(cur[m].w_valid));
      check({p, ".busy"},    32'(busy_o[m]),    32'(cur[m].busy));
      check({p, ".done"},    32'(done_o[m]),    32'(cur[m].done));
      check({p, ".err"},     32'(err_o[m]),     32'(cur[m].err));
      check({p, ".bit_idx"}, 32'(bit_idx_o[m]), 32'(cur[m].bit_idx));
    end
  endtask

  task automatic drive(input logic s, input logic [15:0] p, input logic [4:0] l,
                       input logic [3:0] r, input logic a, input logic rs);
    start = s; pattern = p; len = l; reps = r; abort = a; rst = rs;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 16'h0, 5'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    cur[0] = '0;
    cur[1] = '0;
    // Reset state.
    drive(1'b0, 16'h0, 5'd0, 4'd0, 1'b0, 1'b1);
    tick(); tick();
    idle(2);

    // Basic 12-bit pattern, single transmission.
    drive(1'b1, 16'h0AD1, 5'd12, 4'd0, 1'b0, 1'b0); tick();
    idle(16);

    // Three repetitions of 101; a start while busy must be ignored.
    drive(1'b1, 16'h0005, 5'd3, 4'd2, 1'b0, 1'b0); tick();
    idle(2);
    drive(1'b1, 16'hFFFF, 5'd5, 4'd1, 1'b0, 1'b0); tick();
    idle(14);

    // Rejections: len=0 and len=17.
    drive(1'b1, 16'h1234, 5'd0, 4'd0, 1'b0, 1'b0); tick();
    idle(1);
    drive(1'b1, 16'h1234, 5'd17, 4'd0, 1'b0, 1'b0); tick();
    idle(2);

    // Abort on bit_idx 4 of an 8-bit pattern, then a fresh start.
    drive(1'b1, 16'h00C5, 5'd8, 4'd0, 1'b0, 1'b0); tick();
    idle(3);
    drive(1'b0, 16'h0, 5'd0, 4'd0, 1'b1, 1'b0); tick();
    idle(1);
    drive(1'b1, 16'h0036, 5'd6, 4'd0, 1'b0, 1'b0); tick();
    idle(9);

    // Reset during the third bit, then a normal start.
    drive(1'b1, 16'h00A7, 5'd8, 4'd0, 1'b0, 1'b0); tick();
    idle(2);
    drive(1'b0, 16'h0, 5'd0, 4'd0, 1'b0, 1'b1); tick();
    drive(1'b1, 16'h0001, 5'd1, 4'd1, 1'b0, 1'b0); tick();
    idle(6);

    // Pattern 10 repeated twice with start held high across done.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'h0002, 5'd2, 4'd1, 1'b0, 1'b0);
      tick();
    end
    idle(8);

    // Maximum repetition count with a one-bit pattern.
    drive(1'b1, 16'h0001, 5'd1, 4'd15, 1'b0, 1'b0); tick();
    idle(50);

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 16)       len = 5'(r + 1);
      else if (r == 16) len = 5'd0;
      else              len = 5'($urandom_range(17, 31));
      pattern = 16'($urandom());
      reps    = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
      start   = ($urandom_range(0, 2) == 0);
      abort   = ($urandom_range(0, 49) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      tick();
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
